// File: rtl/dmem_wr_arbiter.sv
// Burst-granted round-robin arbiter for the shared DMEM write port (camera vs SPART host).
// Optional per-requester statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_wr_arbiter #(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned MAX_WAIT  = 64,
  parameter int unsigned AW        = 7,
  parameter int unsigned DW        = 256
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          cam_valid,
  input  logic          cam_last,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_data,
  output logic          cam_ready,
  input  logic          cam_frame_lock,
  input  logic          host_valid,
  input  logic          host_last,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  output logic          dmem_wren,
  output logic [AW-1:0] dmem_wraddr,
  output logic [DW-1:0] dmem_wrdata,
`ifdef DMEM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   cam_beats,
  output logic [15:0]   host_beats,
  output logic [15:0]   conflicts,
`endif
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CAM  = 2'b01,
    S_HOST = 2'b10
  } state_t;

  localparam int unsigned   BCW      = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int unsigned   WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [BCW-1:0] BEAT_END = BCW'(BURST_MAX - 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  state_t          r_state;
  logic            r_last_host;
  logic [BCW-1:0]  r_beat_cnt;
  logic [WCW-1:0]  r_wait_cnt;
  logic            r_cam_ready;
  logic            r_host_ready;
  logic            r_wren;
  logic [AW-1:0]   r_wraddr;
  logic [DW-1:0]   r_wrdata;

  logic w_cam_hs;
  logic w_host_hs;
  logic w_hs;
  logic w_g_valid;
  logic w_g_last;
  logic w_burst_end;

  assign w_cam_hs    = cam_valid & r_cam_ready;
  assign w_host_hs   = host_valid & r_host_ready;
  assign w_hs        = w_cam_hs | w_host_hs;
  assign w_g_valid   = (r_state == S_HOST) ? host_valid : cam_valid;
  assign w_g_last    = (r_state == S_HOST) ? host_last  : cam_last;
  // Granted ready is 1 in CAM/HOST, so a high granted valid is always a handshake.
  assign w_burst_end = !w_g_valid | w_g_last | (r_beat_cnt == BEAT_END);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_host  <= 1'b1;
      r_beat_cnt   <= '0;
      r_cam_ready  <= 1'b0;
      r_host_ready <= 1'b0;
      r_wren       <= 1'b0;
      r_wraddr     <= '0;
      r_wrdata     <= '0;
    end else begin
      r_wren <= w_hs;
      if (w_cam_hs) begin
        r_wraddr <= cam_addr;
        r_wrdata <= cam_data;
      end else if (w_host_hs) begin
        r_wraddr <= host_addr;
        r_wrdata <= host_data;
      end
      case (r_state)
        S_IDLE: begin
          if (host_valid && (r_wait_cnt == WAIT_SAT)) begin
            r_state      <= S_HOST;
            r_host_ready <= 1'b1;
          end else if (cam_valid && (cam_frame_lock || !host_valid || r_last_host)) begin
            r_state     <= S_CAM;
            r_cam_ready <= 1'b1;
          end else if (host_valid) begin
            r_state      <= S_HOST;
            r_host_ready <= 1'b1;
          end
        end
        S_CAM, S_HOST: begin
          if (w_burst_end) begin
            r_state      <= S_IDLE;
            r_cam_ready  <= 1'b0;
            r_host_ready <= 1'b0;
            r_last_host  <= (r_state == S_HOST);
            r_beat_cnt   <= '0;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cam_ready  <= 1'b0;
          r_host_ready <= 1'b0;
          r_beat_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!host_valid || w_host_hs) begin
      r_wait_cnt <= '0;
    end else if ((r_state != S_HOST) && (r_wait_cnt != WAIT_SAT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_cam_beats;
  logic [15:0] r_host_beats;
  logic [15:0] r_conflicts;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cam_beats  <= '0;
      r_host_beats <= '0;
      r_conflicts  <= '0;
    end else if (stats_clr) begin
      r_cam_beats  <= '0;
      r_host_beats <= '0;
      r_conflicts  <= '0;
    end else begin
      if (w_cam_hs)  r_cam_beats  <= r_cam_beats + 16'd1;
      if (w_host_hs) r_host_beats <= r_host_beats + 16'd1;
      if ((r_state == S_IDLE) && cam_valid && host_valid) r_conflicts <= r_conflicts + 16'd1;
    end
  end

  assign cam_beats  = r_cam_beats;
  assign host_beats = r_host_beats;
  assign conflicts  = r_conflicts;
`endif

  assign cam_ready   = r_cam_ready;
  assign host_ready  = r_host_ready;
  assign dmem_wren   = r_wren;
  assign dmem_wraddr = r_wraddr;
  assign dmem_wrdata = r_wrdata;
  assign grant       = r_state;

endmodule

// File: tb/tb_dmem_wr_arbiter.sv
// Self-checking bench for dmem_wr_arbiter: arbitration vector table, scoreboard of DMEM writes,
// and sequences for bursts, burst limit, starvation override and mid-burst reset.
module tb_dmem_wr_arbiter;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 256;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n = 1'b0;
  logic          cam_valid = 1'b0, cam_last = 1'b0, cam_frame_lock = 1'b0;
  logic [AW-1:0] cam_addr = '0;
  logic [DW-1:0] cam_data = '0;
  logic          host_valid = 1'b0, host_last = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          cam_ready, host_ready, dmem_wren;
  logic [AW-1:0] dmem_wraddr;
  logic [DW-1:0] dmem_wrdata;
  logic [1:0]    grant;
`ifdef DMEM_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   cam_beats, host_beats, conflicts;
`endif

  always #5 CLOCK_50 = ~CLOCK_50;

  dmem_wr_arbiter #(.BURST_MAX(8), .MAX_WAIT(64), .AW(AW), .DW(DW)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n),
    .cam_valid(cam_valid), .cam_last(cam_last), .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_ready(cam_ready), .cam_frame_lock(cam_frame_lock),
    .host_valid(host_valid), .host_last(host_last), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready),
    .dmem_wren(dmem_wren), .dmem_wraddr(dmem_wraddr), .dmem_wrdata(dmem_wrdata),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr(stats_clr), .cam_beats(cam_beats), .host_beats(host_beats), .conflicts(conflicts),
`endif
    .grant(grant)
  );

  typedef struct { logic cv; logic hv; logic lk; logic [1:0] g; } vec_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  int     checks = 0;
  int     errors = 0;
  wr_t    sb[$];
  vec_t   vt[10];
  string  g_log = "";
  string  l_log = "";
  int     cur_len = 0;
  logic [1:0] prev_g = 2'b00;

  function automatic logic [DW-1:0] mk(input int tag, input int k);
    logic [31:0] w;
    w = {8'hA5, 8'(tag), 16'(k)};
    return {8{w}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  // Scoreboard: every registered write must match the oldest accepted beat.
  always @(negedge CLOCK_50) begin : mon_wr
    wr_t e;
    if (dmem_wren) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got write addr %0h with empty scoreboard", dmem_wraddr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", DW'(dmem_wraddr), DW'(e.a));
        chk("wr_data", dmem_wrdata, e.d);
      end
    end
  end

  // Grant-order and burst-length log; a direct switch between requesters is an error.
  always @(negedge CLOCK_50) begin : mon_grant
    if (grant != 2'b00 && prev_g != 2'b00 && grant != prev_g) begin
      checks++;
      errors++;
      $display("FAIL idle_gap: got grant %b directly after %b expected 00 between", grant, prev_g);
    end
    if (grant != 2'b00 && prev_g == 2'b00) begin
      if (grant == 2'b01) g_log = {g_log, "C"};
      else                g_log = {g_log, "H"};
      cur_len = 0;
    end
    if ((cam_valid & cam_ready) | (host_valid & host_ready)) cur_len++;
    if (grant == 2'b00 && prev_g != 2'b00) l_log = {l_log, $sformatf("%0d,", cur_len)};
    prev_g = grant;
  end

  task automatic do_reset();
    @(negedge CLOCK_50);
    rst_n = 1'b0;
    cam_valid = 1'b0; cam_last = 1'b0; cam_frame_lock = 1'b0;
    host_valid = 1'b0; host_last = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    g_log = "";
    l_log = "";
  endtask

  task automatic arb_step(input vec_t v, input int idx);
    wr_t e;
    @(negedge CLOCK_50);
    cam_valid = v.cv; host_valid = v.hv; cam_frame_lock = v.lk;
    cam_last = 1'b1; host_last = 1'b1;
    cam_addr = AW'(idx * 2); host_addr = AW'(idx * 2 + 1);
    cam_data = mk(1, idx); host_data = mk(2, idx);
    @(posedge CLOCK_50); #1;
    chk($sformatf("vec%0d_grant", idx), DW'(grant), DW'(v.g));
    chk($sformatf("vec%0d_ready", idx), DW'({host_ready, cam_ready}), DW'(v.g));
    if (v.g == 2'b01) begin e.a = cam_addr; e.d = cam_data; sb.push_back(e); end
    if (v.g == 2'b10) begin e.a = host_addr; e.d = host_data; sb.push_back(e); end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    cam_valid = 1'b0; host_valid = 1'b0; cam_frame_lock = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic cam_send(input int n, input int blen, input int base);
    int to;
    wr_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge CLOCK_50);
      cam_valid = 1'b1; cam_addr = AW'(base + k); cam_data = mk(1, base + k);
      cam_last = (blen > 0) && ((k % blen) == blen - 1);
      to = 0;
      while (!cam_ready && to < 500) begin @(negedge CLOCK_50); to++; end
      if (!cam_ready) begin
        checks++; errors++;
        $display("FAIL cam_timeout: beat %0d got no ready expected ready within 500 cycles", k);
        break;
      end
      e.a = cam_addr; e.d = cam_data; sb.push_back(e);
    end
    @(negedge CLOCK_50);
    cam_valid = 1'b0; cam_last = 1'b0;
  endtask

  task automatic host_send(input int n, input int blen, input int base);
    int to;
    wr_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge CLOCK_50);
      host_valid = 1'b1; host_addr = AW'(base + k); host_data = mk(2, base + k);
      host_last = (blen > 0) && ((k % blen) == blen - 1);
      to = 0;
      while (!host_ready && to < 500) begin @(negedge CLOCK_50); to++; end
      if (!host_ready) begin
        checks++; errors++;
        $display("FAIL host_timeout: beat %0d got no ready expected ready within 500 cycles", k);
        break;
      end
      e.a = host_addr; e.d = host_data; sb.push_back(e);
    end
    @(negedge CLOCK_50);
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  initial begin : main
    vec_t v;
    wr_t  e;
    // last_served starts as HOST; expected grants follow the IDLE priority rules in order.
    vt[0] = '{1'b1, 1'b0, 1'b0, 2'b01};
    vt[1] = '{1'b1, 1'b1, 1'b0, 2'b10};
    vt[2] = '{1'b1, 1'b1, 1'b0, 2'b01};
    vt[3] = '{1'b1, 1'b1, 1'b1, 2'b01};
    vt[4] = '{1'b0, 1'b1, 1'b0, 2'b10};
    vt[5] = '{1'b0, 1'b0, 1'b0, 2'b00};
    vt[6] = '{1'b1, 1'b1, 1'b0, 2'b01};
    vt[7] = '{1'b1, 1'b0, 1'b1, 2'b01};
    vt[8] = '{1'b1, 1'b1, 1'b0, 2'b10};
    vt[9] = '{1'b0, 1'b1, 1'b1, 2'b10};

    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_grant", DW'(grant), '0);
    chk("rst_ready", DW'({host_ready, cam_ready}), '0);
    chk("rst_wren", DW'(dmem_wren), '0);
    chk("rst_addr", DW'(dmem_wraddr), '0);
    chk("rst_data", dmem_wrdata, '0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) arb_step(vt[i], i);

    // T1: cam-only 4-beat burst
    do_reset();
    @(negedge CLOCK_50);
    cam_valid = 1'b1; cam_addr = '0; cam_data = mk(3, 0); cam_last = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("t1_grant", DW'(grant), DW'(2'b01));
    chk("t1_ready", DW'(cam_ready), DW'(1'b1));
    chk("t1_wren0", DW'(dmem_wren), '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK_50);
      cam_addr = AW'(k); cam_data = mk(3, k); cam_last = (k == 3);
      e.a = cam_addr; e.d = cam_data; sb.push_back(e);
      @(posedge CLOCK_50); #1;
      chk($sformatf("t1_wren%0d", k), DW'(dmem_wren), DW'(1'b1));
      chk($sformatf("t1_addr%0d", k), DW'(dmem_wraddr), DW'(k));
    end
    chk("t1_grant_end", DW'(grant), '0);
    chk("t1_ready_end", DW'(cam_ready), '0);
    @(negedge CLOCK_50);
    cam_valid = 1'b0; cam_last = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("t1_wren_idle", DW'(dmem_wren), '0);
    chk("t1_addr_hold", DW'(dmem_wraddr), DW'(3));

    // T2: both requesters, bursts of 2, alternating
    do_reset();
    fork
      cam_send(4, 2, 0);
      host_send(4, 2, 64);
    join
    repeat (3) @(negedge CLOCK_50);
    chk_s("t2_order", g_log, "CHCH");
    chk_s("t2_lens", l_log, "2,2,2,2,");

    // T3: unterminated cam burst is cut at BURST_MAX
    do_reset();
    fork
      cam_send(20, 0, 0);
      host_send(2, 2, 64);
    join
    repeat (3) @(negedge CLOCK_50);
    chk_s("t3_order", g_log, "CHCC");
    chk_s("t3_lens", l_log, "8,2,8,4,");

    // T4: frame lock holds the host off until its wait counter saturates at 64
    do_reset();
    cam_frame_lock = 1'b1;
    fork
      cam_send(72, 0, 0);
      host_send(1, 1, 100);
    join
    cam_frame_lock = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk_s("t4_order", g_log, "CCCCCCCCHC");
    chk_s("t4_lens", l_log, "8,8,8,8,8,8,8,8,1,8,");
    chk("t4_wait_clr", DW'(dut.r_wait_cnt), '0);

    // T5: reset during a host burst drops it and restores cam tie priority
    do_reset();
    v = '{1'b1, 1'b0, 1'b0, 2'b01};
    arb_step(v, 20);
    @(negedge CLOCK_50);
    host_valid = 1'b1; host_last = 1'b0; host_addr = AW'(40); host_data = mk(4, 40);
    @(posedge CLOCK_50); #1;
    chk("t5_grant", DW'(grant), DW'(2'b10));
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      host_addr = AW'(40 + k); host_data = mk(4, 40 + k);
      e.a = host_addr; e.d = host_data; sb.push_back(e);
      @(posedge CLOCK_50);
    end
    @(negedge CLOCK_50);
    host_addr = AW'(43); host_data = mk(4, 43);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_wren", DW'(dmem_wren), '0);
    chk("t5_rst_ready", DW'({host_ready, cam_ready}), '0);
    chk("t5_rst_grant", DW'(grant), '0);
    chk("t5_rst_addr", DW'(dmem_wraddr), '0);
    @(negedge CLOCK_50);
    host_valid = 1'b0;
    rst_n = 1'b1;
    v = '{1'b1, 1'b1, 1'b0, 2'b01};
    arb_step(v, 21);

`ifdef DMEM_ARB_STATS_EN
    // T6: statistics counters
    do_reset();
    fork
      cam_send(5, 2, 0);
      host_send(5, 2, 64);
    join
    repeat (2) @(negedge CLOCK_50);
    chk("t6_cam_beats", DW'(cam_beats), DW'(5));
    chk("t6_host_beats", DW'(host_beats), DW'(5));
    chk("t6_conflicts", DW'(conflicts >= 16'd1), DW'(1'b1));
    stats_clr = 1'b1;
    @(negedge CLOCK_50);
    stats_clr = 1'b0;
    #1;
    chk("t6_clr", DW'({cam_beats, host_beats, conflicts}), '0);
`endif

    repeat (3) @(negedge CLOCK_50);
    chk("sb_empty", DW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
